// File: rtl/dcache_refill_engine.sv
// dCache miss-repair responder: optional dirty-victim writeback, then an
// eight-beat block fetch returned to the controller with a one-cycle pulse.
`timescale 1ns/1ps

// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a read/write miss; latches request on entry
// WB      | writing victim beats to memory, one per accepted request
// RD_REQ  | presenting the block read request until accepted
// RD_DATA | capturing read beats in order into fill_data
// RESOLVE | one-cycle repair_resolved pulse, then back to IDLE
module dcache_refill_engine #(
  parameter int BLOCK_BITS  = 1024,
  parameter int BEAT_BITS   = 128,
  parameter int OFFSET_BITS = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_miss_repair,
  input  logic                  write_miss_repair,
  input  logic [31:0]           missed_addr,
  input  logic                  evict_dirty,
  input  logic [31:0]           evict_addr,
  input  logic [BLOCK_BITS-1:0] evict_data,
  output logic                  repair_resolved,
  output logic [BLOCK_BITS-1:0] fill_data,
  output logic                  fill_is_write,
  output logic                  busy,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [31:0]           mem_req_addr,
  output logic [BEAT_BITS-1:0]  mem_wdata,
  input  logic                  mem_rdata_valid,
  input  logic [BEAT_BITS-1:0]  mem_rdata
);

  localparam int BEATS   = BLOCK_BITS / BEAT_BITS;
  localparam int CNT_W   = $clog2(BEATS);
  localparam int BYTE_SH = $clog2(BEAT_BITS / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB      = 3'd1,
    RD_REQ  = 3'd2,
    RD_DATA = 3'd3,
    RESOLVE = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      beat_cnt, beat_cnt_nxt;
  logic [31:0]           base_addr;
  logic [31:0]           evict_base;
  logic [BLOCK_BITS-1:0] victim;
  logic                  latch_req;
  logic                  capture_beat;
  logic                  req;

  // Offset bits of the incoming addresses are discarded by block alignment.
  logic unused_offsets;
  assign unused_offsets = ^{missed_addr[OFFSET_BITS-1:0], evict_addr[OFFSET_BITS-1:0]};

  assign req = read_miss_repair | write_miss_repair;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    beat_cnt_nxt    = beat_cnt;
    latch_req       = 1'b0;
    capture_beat    = 1'b0;
    repair_resolved = 1'b0;
    busy            = (state != IDLE);
    mem_req_valid   = 1'b0;
    mem_req_we      = 1'b0;
    mem_req_addr    = '0;
    mem_wdata       = '0;

    case (state)
      IDLE: begin
        if (req) begin
          latch_req    = 1'b1;
          beat_cnt_nxt = '0;
          state_nxt    = evict_dirty ? WB : RD_REQ;
        end
      end

      WB: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = evict_base + (32'(beat_cnt) << BYTE_SH);
        mem_wdata     = victim[int'(beat_cnt) * BEAT_BITS +: BEAT_BITS];
        if (mem_req_ready) begin
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
          if (beat_cnt == LAST_BEAT) state_nxt = RD_REQ;
        end
      end

      RD_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = base_addr;
        if (mem_req_ready) begin
          beat_cnt_nxt = '0;
          state_nxt    = RD_DATA;
        end
      end

      RD_DATA: begin
        if (mem_rdata_valid) begin
          capture_beat = 1'b1;
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
          if (beat_cnt == LAST_BEAT) state_nxt = RESOLVE;
        end
      end

      RESOLVE: begin
        repair_resolved = 1'b1;
        state_nxt       = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Request context is frozen at acceptance; later input changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_addr     <= '0;
      evict_base    <= '0;
      victim        <= '0;
      fill_is_write <= 1'b0;
    end else if (latch_req) begin
      base_addr     <= {missed_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
      evict_base    <= {evict_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
      victim        <= evict_data;
      fill_is_write <= write_miss_repair;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_data <= '0;
    end else if (capture_beat) begin
      fill_data[int'(beat_cnt) * BEAT_BITS +: BEAT_BITS] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dcache_refill_engine.sv
// Self-checking bench for dcache_refill_engine: directed vector table, reset
// and back-to-back sequences, and randomized repairs against a transaction model.
`timescale 1ns/1ps

module tb_dcache_refill_engine;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          read_miss_repair = 1'b0;
  logic          write_miss_repair = 1'b0;
  logic [31:0]   missed_addr = '0;
  logic          evict_dirty = 1'b0;
  logic [31:0]   evict_addr = '0;
  logic [1023:0] evict_data = '0;
  logic          repair_resolved;
  logic [1023:0] fill_data;
  logic          fill_is_write;
  logic          busy;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic          mem_req_we;
  logic [31:0]   mem_req_addr;
  logic [127:0]  mem_wdata;
  logic          mem_rdata_valid = 1'b0;
  logic [127:0]  mem_rdata = '0;

  always #5 clk = ~clk;

  dcache_refill_engine dut (
    .clk               (clk),
    .rst               (rst),
    .read_miss_repair  (read_miss_repair),
    .write_miss_repair (write_miss_repair),
    .missed_addr       (missed_addr),
    .evict_dirty       (evict_dirty),
    .evict_addr        (evict_addr),
    .evict_data        (evict_data),
    .repair_resolved   (repair_resolved),
    .fill_data         (fill_data),
    .fill_is_write     (fill_is_write),
    .busy              (busy),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_we        (mem_req_we),
    .mem_req_addr      (mem_req_addr),
    .mem_wdata         (mem_wdata),
    .mem_rdata_valid   (mem_rdata_valid),
    .mem_rdata         (mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [127:0] data;
  } txn_t;

  txn_t exp_q[$];

  typedef struct {
    bit          rd;
    bit          wr;
    bit          dirty;
    bit          stall;
    bit          gapped;
    bit          b2b;
    logic [31:0] maddr;
    logic [31:0] eaddr;
    int          exp_lat;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_blk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s_beat%0d", name, k), act[k*128 +: 128], exp[k*128 +: 128]);
  endtask

  function automatic logic [1023:0] rand_blk();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [1023:0] pattern_blk(input int seed);
    logic [1023:0] r;
    logic [31:0] w;
    for (int k = 0; k < 8; k++) begin
      w = 32'(32'hA0 + k + seed * 256);
      r[k*128 +: 128] = {4{w}};
    end
    return r;
  endfunction

  function automatic logic [1023:0] index_blk();
    logic [1023:0] r;
    for (int k = 0; k < 8; k++) r[k*128 +: 128] = 128'(k);
    return r;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_resolved"}, 128'(repair_resolved), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_valid"}, 128'(mem_req_valid), 128'(0));
    chk({tag, "_we"}, 128'(mem_req_we), 128'(0));
    chk({tag, "_is_write"}, 128'(fill_is_write), 128'(0));
    chk({tag, "_addr"}, 128'(mem_req_addr), 128'(0));
    chk({tag, "_wdata"}, mem_wdata, 128'(0));
    chk_blk({tag, "_fill"}, fill_data, '0);
  endtask

  // Called at a cycle where the DUT is idle; drives the request, plays the
  // memory side and returns when repair_resolved is observed.
  task automatic do_repair(input bit rd, input bit wr, input bit dirty,
                           input logic [31:0] maddr, input logic [31:0] eaddr,
                           input logic [1023:0] edata, input logic [1023:0] mem_blk,
                           input bit stall, input bit gapped, input bit rnd,
                           output int lat, output logic [1023:0] fill, output bit is_wr,
                           output int stalls, output int gaps);
    logic [31:0]  base;
    logic [31:0]  ebase;
    logic [31:0]  p_addr;
    logic         p_we;
    logic [127:0] p_wdata;
    int           hs;
    int           beats;
    int           stall_used;
    int           rd_idx;
    bit           rd_acc;
    bit           prev_stall;
    bit           gap_phase;
    txn_t         t;

    base  = {maddr[31:7], 7'b0};
    ebase = {eaddr[31:7], 7'b0};
    exp_q.delete();
    if (dirty)
      for (int k = 0; k < 8; k++) begin
        t.we = 1'b1; t.addr = ebase + 32'(16 * k); t.data = edata[k*128 +: 128];
        exp_q.push_back(t);
      end
    t.we = 1'b0; t.addr = base; t.data = '0;
    exp_q.push_back(t);

    hs = 0; beats = 0; stall_used = 0; rd_idx = dirty ? 8 : 0;
    rd_acc = 0; prev_stall = 0; gap_phase = 0;
    p_addr = '0; p_we = 1'b0; p_wdata = '0;
    stalls = 0; gaps = 0; lat = -1; fill = '0; is_wr = 1'b0;

    chk("idle_busy", 128'(busy), 128'(0));
    chk("idle_no_resolve", 128'(repair_resolved), 128'(0));
    read_miss_repair  = rd;
    write_miss_repair = wr;
    missed_addr       = maddr;
    evict_dirty       = dirty;
    evict_addr        = eaddr;
    evict_data        = edata;
    mem_req_ready     = 1'b0;
    mem_rdata_valid   = 1'b0;

    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      // Evict inputs are only meaningful at acceptance; scramble them afterwards.
      evict_dirty = 1'($urandom);
      evict_addr  = $urandom;
      evict_data  = rand_blk();
      chk("busy_active", 128'(busy), 128'(1));
      if (repair_resolved) begin
        lat = n; fill = fill_data; is_wr = fill_is_write;
        mem_req_ready = 1'b0; mem_rdata_valid = 1'b0;
        break;
      end
      if (prev_stall) begin
        chk("hold_valid", 128'(mem_req_valid), 128'(1));
        chk("hold_addr", 128'(mem_req_addr), 128'(p_addr));
        chk("hold_we", 128'(mem_req_we), 128'(p_we));
        chk("hold_wdata", mem_wdata, p_wdata);
      end

      mem_rdata_valid = 1'b0;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (rd_acc && beats < 8) begin
        bit send;
        if (gapped) begin send = !gap_phase; gap_phase = !gap_phase; end
        else if (rnd) send = ($urandom_range(0, 2) != 0);
        else send = 1'b1;
        if (send) begin
          mem_rdata_valid = 1'b1;
          mem_rdata = mem_blk[beats*128 +: 128];
          beats++;
        end else gaps++;
      end else if (rnd) begin
        mem_rdata_valid = 1'($urandom_range(0, 1));
      end

      mem_req_ready = 1'b0;
      prev_stall = 1'b0;
      if (mem_req_valid) begin
        bit rdy;
        if (rnd) rdy = ($urandom_range(0, 3) != 0);
        else rdy = !(stall && (hs == 2 || hs == rd_idx) && stall_used < 3);
        if (rdy) begin
          mem_req_ready = 1'b1;
          hs++;
          stall_used = 0;
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL extra_request: got addr %0h we %0b, expected none", mem_req_addr, mem_req_we);
          end else begin
            t = exp_q.pop_front();
            chk("req_we", 128'(mem_req_we), 128'(t.we));
            chk("req_addr", 128'(mem_req_addr), 128'(t.addr));
            if (t.we) chk("req_wdata", mem_wdata, t.data);
            if (!t.we) rd_acc = 1'b1;
          end
        end else begin
          stalls++;
          stall_used++;
          prev_stall = 1'b1;
          p_addr = mem_req_addr; p_we = mem_req_we; p_wdata = mem_wdata;
        end
      end else if (rnd) begin
        mem_req_ready = 1'($urandom_range(0, 1));
      end
    end

    if (lat < 0) begin
      n_checks++; n_fail++;
      $display("FAIL resolve_timeout: got no repair_resolved in 300 cycles, expected one");
    end
    chk("requests_left", 128'(exp_q.size()), 128'(0));
    chk("beats_sent", 128'(beats), 128'(8));
  endtask

  initial begin
    int            lat;
    logic [1023:0] fill;
    bit            is_wr;
    int            stalls;
    int            gaps;
    logic [1023:0] blk;
    logic [1023:0] vic;
    bit            rd;
    bit            wr;
    bit            dirty;
    int            beats;
    bit            acc;

    //             rd wr dt st gp b2b maddr          eaddr          lat
    tbl[0] = '{1, 0, 0, 0, 0, 0, 32'h0000_1234, 32'h0000_0000, 10};
    tbl[1] = '{0, 1, 1, 0, 0, 0, 32'h0000_5678, 32'h0000_8080, 18};
    tbl[2] = '{1, 0, 1, 1, 0, 0, 32'h2345_6789, 32'h0001_0000, 24};
    tbl[3] = '{1, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 32'h0000_0000, 17};
    tbl[4] = '{1, 1, 0, 0, 0, 0, 32'h0000_0ABC, 32'h0000_0000, 10};
    tbl[5] = '{1, 0, 1, 0, 0, 1, 32'h0000_4000, 32'h0000_3FFF, 18};

    #1;
    check_reset_vals("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      if (!tbl[i].b2b) begin
        read_miss_repair = 1'b0; write_miss_repair = 1'b0;
        @(posedge clk); #1;
      end
      blk = pattern_blk(i);
      vic = index_blk();
      do_repair(tbl[i].rd, tbl[i].wr, tbl[i].dirty, tbl[i].maddr, tbl[i].eaddr, vic, blk,
                tbl[i].stall, tbl[i].gapped, 1'b0, lat, fill, is_wr, stalls, gaps);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(tbl[i].exp_lat));
      chk($sformatf("vec%0d_is_write", i), 128'(is_wr), 128'(tbl[i].wr));
      chk_blk($sformatf("vec%0d_fill", i), fill, blk);
      @(posedge clk); #1;
    end
    chk("fill_held_after_resolve", fill_data[127:0], pattern_blk(5) & 1024'({128{1'b1}}));

    // Reset in the middle of the read data phase, after beat 4 is captured.
    read_miss_repair = 1'b0; write_miss_repair = 1'b0;
    @(posedge clk); #1;
    read_miss_repair = 1'b1; missed_addr = 32'h0000_7777; evict_dirty = 1'b0;
    mem_req_ready = 1'b1; mem_rdata_valid = 1'b0;
    beats = 0; acc = 0;
    for (int n = 1; n <= 40 && beats < 5; n++) begin
      @(posedge clk); #1;
      mem_rdata_valid = 1'b0;
      if (acc) begin
        mem_rdata_valid = 1'b1;
        mem_rdata = {4{32'hDEAD_0000 + 32'(beats)}};
        beats++;
      end
      if (mem_req_valid && !mem_req_we) acc = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rdata_valid = 1'b0; mem_req_ready = 1'b0;
    #1;
    check_reset_vals("midfill_reset");
    read_miss_repair = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      chk("no_resolve_in_reset", 128'(repair_resolved), 128'(0));
    end
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      chk("no_resolve_after_reset", 128'(repair_resolved), 128'(0));
    end
    blk = rand_blk();
    do_repair(1'b1, 1'b0, 1'b0, 32'h0000_7777, 32'h0, '0, blk, 1'b0, 1'b0, 1'b0,
              lat, fill, is_wr, stalls, gaps);
    chk("post_reset_latency", 128'(lat), 128'(10));
    chk_blk("post_reset_fill", fill, blk);
    @(posedge clk); #1;

    // Randomized repairs; latency follows from the stalls and gaps the bench inserted.
    for (int i = 0; i < 24; i++) begin
      rd = 1'($urandom); wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      dirty = 1'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        read_miss_repair = 1'b0; write_miss_repair = 1'b0;
        @(posedge clk); #1;
      end
      blk = rand_blk();
      vic = rand_blk();
      do_repair(rd, wr, dirty, $urandom, $urandom, vic, blk, 1'b0, 1'b0, 1'b1,
                lat, fill, is_wr, stalls, gaps);
      chk($sformatf("rnd%0d_latency", i), 128'(lat),
          128'(10 + (dirty ? 8 : 0) + stalls + gaps));
      chk($sformatf("rnd%0d_is_write", i), 128'(is_wr), 128'(wr));
      chk_blk($sformatf("rnd%0d_fill", i), fill, blk);
      @(posedge clk); #1;
    end
    read_miss_repair = 1'b0; write_miss_repair = 1'b0;
    @(posedge clk); #1;
    chk("final_idle", 128'(busy), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
